// File: rtl/mux_lut_cell_if.sv
// Handshake and configuration bundle for mux_lut_cell.
// The slave view belongs to the cell and the master view to whatever drives it.
interface mux_lut_cell_if #(
  parameter int unsigned N_IN = 2
);
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            cfg_done;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_data;

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    output cfg_ready, cfg_done, in_ready, out_valid, out_data
  );

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_done, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mux_lut_cell.sv
// Programmable N_IN-input lookup cell: a 2:1 mux tree selects from the active table.
// The table is reloaded serially through a shadow register and committed atomically.
module lut_mux2 (
  input  logic a0,
  input  logic a1,
  input  logic s,
  output logic y
);
  assign y = s ? a1 : a0;
endmodule

module mux_lut_cell #(
  parameter int unsigned           N_IN        = 2,
  parameter logic [(2**N_IN)-1:0]  RESET_TABLE = 4'b0101
) (
  input logic           clk,
  input logic           rst_n,
  mux_lut_cell_if.slave bus
);
  localparam int unsigned T     = 2**N_IN;
  localparam int unsigned CW    = $clog2(T + 1);
  localparam int unsigned NODES = 2*T - 1;

  typedef enum logic {RUN, LOAD} state_t;

  state_t        state, state_nx;
  logic [T-1:0]  active_tbl, active_tbl_nx;
  logic [T-1:0]  shadow, shadow_nx;
  logic [CW-1:0] count, count_nx;
  logic          commit;
  logic          cfg_done_q;
  logic          out_valid_q;
  logic          out_data_q;
  logic          in_ready_w;
  logic          accept;
  logic          result;

  // Tree nodes stored level by level: leaves first, root last.
  function automatic int unsigned level_off(input int unsigned lvl);
    return 2*T - 2*(T >> lvl);
  endfunction

  logic [NODES-1:0] node;
  assign node[T-1:0] = active_tbl;

  for (genvar j = 1; j <= N_IN; j++) begin : g_lvl
    for (genvar i = 0; i < (T >> j); i++) begin : g_mux
      lut_mux2 u_mux (
        .a0 (node[level_off(j-1) + 2*i]),
        .a1 (node[level_off(j-1) + 2*i + 1]),
        .s  (bus.in_data[j-1]),
        .y  (node[level_off(j) + i])
      );
    end
  end

  assign result = node[NODES-1];

  always_comb begin
    state_nx      = state;
    count_nx      = count;
    shadow_nx     = shadow;
    active_tbl_nx = active_tbl;
    commit        = 1'b0;
    case (state)
      RUN: begin
        if (bus.cfg_start) begin
          state_nx  = LOAD;
          count_nx  = '0;
          shadow_nx = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_start) begin
          count_nx  = '0;
          shadow_nx = '0;
        end else if (bus.cfg_valid) begin
          for (int unsigned k = 0; k < T; k++) begin
            if (count == CW'(k)) shadow_nx[k] = bus.cfg_bit;
          end
          if (count == CW'(T - 1)) begin
            // Final beat bypasses shadow so the commit lands on this same edge.
            commit        = 1'b1;
            active_tbl_nx = shadow_nx;
            state_nx      = RUN;
            count_nx      = '0;
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      active_tbl <= RESET_TABLE;
      shadow     <= '0;
      count      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state      <= state_nx;
      active_tbl <= active_tbl_nx;
      shadow     <= shadow_nx;
      count      <= count_nx;
      cfg_done_q <= commit;
    end
  end

  assign in_ready_w = !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && in_ready_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= result;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.cfg_ready = (state == LOAD);
  assign bus.cfg_done  = cfg_done_q;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule
